// File: rtl/addsub_seq_pkg.sv
// addsub_seq shared definitions.
// State encoding and operation-mode constants.
package addsub_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Subtraction is A + ~B + 1 - borrow, so the chain
   // starts with the inverted borrow.
   function automatic logic init_carry(
      input logic mode,
      input logic ci
   );
      return (mode == MODE_SUB) ? ~ci : ci;
   endfunction

endpackage

// File: rtl/addsub_seq_chunk.sv
// CHUNK-bit ripple adder slice.
// Shared over all chunks of an operation.
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder u_fa (
         .a  (x[i]),
         .b  (y[i]),
         .ci (w_c[i]),
         .s  (s[i]),
         .co (w_c[i+1])
      );
   end

   assign co = w_c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Building block of the chunk ripple.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic w_p;

   assign w_p = a ^ b;
   assign s   = w_p ^ ci;
   assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub, sign-magnitude result.
// One CHUNK slice per cycle, LSB first.
module addsub_seq
   import addsub_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   res,
   output logic             neg,
   output logic             c_out,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [IDXW-1:0] LAST    = IDXW'(NCHUNK - 1);
   localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
   localparam logic [WIDTH:0]  RES_ONE = (WIDTH + 1)'(1);

   if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("addsub_seq: WIDTH must be a multiple of CHUNK");
   end

   state_t r_state;
   state_t w_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_mode;
   logic             r_carry;
   logic [IDXW-1:0]  r_idx;

   logic [WIDTH:0]   r_res;
   logic             r_neg;
   logic             r_cout;
   logic             r_zero;

   logic             w_accept;
   logic             w_last;
   logic [CHUNK-1:0] w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_ins;
   logic [WIDTH:0]   w_res;
   logic             w_neg;

   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_idx == LAST);

   addsub_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .x  (r_a[CHUNK-1:0]),
      .y  (r_b[CHUNK-1:0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // New slice enters at the top; after NCHUNK
   // shifts the first slice lands at bit 0.
   assign w_ins = WIDTH'(w_s) << (WIDTH - CHUNK);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (in_valid) w_next = CALC;
         CALC: if (w_last) w_next = FIX;
         FIX:  w_next = DONE;
         DONE: if (out_ready) w_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // Operand capture and chunk-serial ripple.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_mode  <= MODE_ADD;
         r_carry <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b ^ {WIDTH{mode}};
         r_sum   <= '0;
         r_mode  <= mode;
         r_carry <= init_carry(mode, c_in);
         r_idx   <= '0;
      end else if (r_state == CALC) begin
         r_a     <= r_a >> CHUNK;
         r_b     <= r_b >> CHUNK;
         r_sum   <= (r_sum >> CHUNK) | w_ins;
         r_carry <= w_co;
         r_idx   <= r_idx + IDX_ONE;
      end
   end

   // Sign-magnitude fix-up of the raw chain result.
   always_comb begin
      w_neg = 1'b0;
      w_res = {r_carry, r_sum};
      if (r_mode == MODE_SUB) begin
         w_neg = ~r_carry;
         if (w_neg) begin
            w_res = {1'b0, ~r_sum} + RES_ONE;
         end else begin
            w_res = {1'b0, r_sum};
         end
      end
   end

   // Result registers, loaded once in FIX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res  <= '0;
         r_neg  <= 1'b0;
         r_cout <= 1'b0;
         r_zero <= 1'b0;
      end else if (r_state == FIX) begin
         r_res  <= w_res;
         r_neg  <= w_neg;
         r_cout <= r_carry;
         r_zero <= (w_res == '0);
      end
   end

   assign res   = r_res;
   assign neg   = r_neg;
   assign c_out = r_cout;
   assign zero  = r_zero;

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Parametrised multi-cycle unsigned adder/subtractor with carry/borrow-in. It processes CHUNK bits per clock through a ripple slice and returns a sign-magnitude result, so a negative difference comes back as its magnitude plus a sign flag. Operands enter and results leave through valid/ready handshakes. It sits between the operand-entry logic and the display/ALU result path, and replaces the fixed 4-bit combinational add/sub stage.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits resolved per CALC cycle; NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept operands
a  input  WIDTH  unsigned operand A
b  input  WIDTH  unsigned operand B
c_in  input  1  carry-in (add) / borrow-in (sub)
mode  input  1  0 = A+B+c_in, 1 = A-B-c_in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
res  output  WIDTH+1  add: {carry, sum}; sub: |A-B-c_in|
neg  output  1  sub result negative (always 0 for add)
c_out  output  1  final raw carry of the ripple chain
zero  output  1  res == 0

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset: state = IDLE. in_ready = 1, out_valid = 0, res = 0, neg = 0, c_out = 0, zero = 0. Internal operand, partial-sum and carry registers are cleared.
- States and transitions:
  - IDLE -> CALC on in_valid & in_ready. Capture a, b ^ {WIDTH{mode}}, mode. Initial carry = mode ? ~c_in : c_in.
  - CALC: one CHUNK slice per cycle, LSB first. The slice carry-out is registered into the next slice. Chunk index counts 0..NCHUNK-1; after the last slice go to FIX.
  - FIX (1 cycle):
    - c = final carry; c_out = c.
    - Add: res = {c, sum}, neg = 0.
    - Sub: neg = ~c. If neg, res = {1'b0, ~sum} + 1 (WIDTH+1-bit arithmetic). Otherwise res = {1'b0, sum}.
    - zero = (res == 0). Then go to DONE.
  - DONE: out_valid = 1; res, neg, c_out and zero are held stable. On out_ready go to IDLE; out_valid drops on the next cycle.
- in_ready = 1 only in IDLE. Operands are not sampled in any other state, and their changes there have no effect.
- Latency: handshake edge to out_valid high = NCHUNK + 1 cycles. Minimum initiation interval = NCHUNK + 3 cycles with out_ready held high.
- Range: sub results run from -(2^WIDTH) to 2^WIDTH - 1. A magnitude of 2^WIDTH (A=0, B=max, borrow-in=1) sets res[WIDTH] = 1.
- Zero result in sub gives neg = 0; there is no negative zero.
- Outputs keep their last value after the DONE->IDLE transition until the next FIX overwrites them; only out_valid qualifies them.
- Reset asserted in any state returns to IDLE immediately. An in-flight operation is discarded and no result is emitted.
- Simultaneous out_ready and new in_valid in DONE: the result is consumed and the new operands are ignored; they are accepted in IDLE on a following cycle.
- WIDTH % CHUNK != 0 is illegal. Elaboration must fail via a generate-time check.

Decomposition:
- Shared package/header holds the state encoding localparams (IDLE=0, CALC=1, FIX=2, DONE=3) and the MODE_ADD/MODE_SUB constants.
- One sub-module, addsub_chunk: CHUNK-bit ripple built from the existing full_adder cell.
  - Inputs: x[CHUNK], y[CHUNK], ci.
  - Outputs: s[CHUNK], co.
  - Purely combinational; instantiated once and time-multiplexed over the chunks.

Test Plan:
- Reset mid-CALC: WIDTH=8, start a=200 b=100 mode=1, assert rst_n=0 on cycle 2 -> in_ready=1, out_valid=0, res=0 immediately; no result is ever emitted.
- Add with carry: a=255, b=1, c_in=1, mode=0 -> res=257 (9'h101), c_out=1, neg=0, zero=0, out_valid exactly NCHUNK+1=3 cycles after accept.
- Sub positive: a=200, b=55, c_in=0, mode=1 -> res=145, neg=0, c_out=1.
- Sub negative and extreme: a=3, b=10, c_in=0 -> res=7, neg=1. Then a=0, b=255, c_in=1 -> res=256, neg=1, c_out=0.
- Sub zero: a=77, b=76, c_in=1 -> res=0, zero=1, neg=0.
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles with in_valid held high -> outputs stable, in_ready=0, second operand not taken. Release out_ready -> first result consumed, second accepted in IDLE, second result correct. Repeat with CHUNK=1 and CHUNK=8 at WIDTH=8.
